// File: rtl/multicycle_controller_pkg.sv
// ctrl_pkg: shared types and constants for the multi-cycle MIPS-subset controller.
//   state_t    : FSM state encoding (also exported on the debug 'state' output)
//   class_t    : instruction class latched in DECODE
//   ctrl_out_t : bundle of all strobes/selects produced by the output decode
//   OP_*/FUNC_*: opcode and function-field constants, is_shift() helper
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_JUMP    = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    CL_R, CL_JR, CL_LW, CL_SW, CL_BEQ, CL_BNE, CL_J, CL_JAL, CL_I, CL_ILLEGAL
  } class_t;

  localparam logic [5:0] OP_R_FORMAT = 6'h00;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_SW       = 6'h2B;
  localparam logic [5:0] OP_BRANCH   = 6'h04;
  localparam logic [5:0] OP_NBRANCH  = 6'h05;
  localparam logic [5:0] OP_JMP      = 6'h02;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [2:0] OP_I_FORMAT = 3'b001;  // matched against op[5:3]

  localparam logic [5:0] FUNC_JR   = 6'h08;
  localparam logic [5:0] FUNC_SLL  = 6'h00;
  localparam logic [5:0] FUNC_SRL  = 6'h02;
  localparam logic [5:0] FUNC_SRA  = 6'h03;
  localparam logic [5:0] FUNC_SLLV = 6'h04;
  localparam logic [5:0] FUNC_SRLV = 6'h06;
  localparam logic [5:0] FUNC_SRAV = 6'h07;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src;
    logic       sftmd;
    logic       i_format;
    logic       jr;
    logic       jmp;
    logic       jal;
    logic       branch;
    logic       nbranch;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal;
  } ctrl_out_t;

  function automatic logic is_shift(input logic [5:0] f);
    return (f == FUNC_SLL)  || (f == FUNC_SRL)  || (f == FUNC_SRA) ||
           (f == FUNC_SLLV) || (f == FUNC_SRLV) || (f == FUNC_SRAV);
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: controller <-> datapath/IR/memory signal bundle.
//   master : controller side (drives strobes, selects, status)
//   slave  : datapath side (drives run/op/func/mem_ready)
interface multicycle_controller_if #(
  parameter int OP_WIDTH   = 6,
  parameter int FUNC_WIDTH = 6
);
  logic                  run;
  logic [OP_WIDTH-1:0]   op;
  logic [FUNC_WIDTH-1:0] func;
  logic                  mem_ready;

  logic pc_write, ir_write, mem_read, mem_write, reg_write;
  logic reg_dst, mem_to_reg, alu_src, sftmd, i_format;
  logic jr, jmp, jal, branch, nbranch;
  logic [1:0] alu_op;
  logic instr_done, illegal, mem_err;
  logic [2:0] state;

  modport master (
    input  run, op, func, mem_ready,
    output pc_write, ir_write, mem_read, mem_write, reg_write,
           reg_dst, mem_to_reg, alu_src, sftmd, i_format,
           jr, jmp, jal, branch, nbranch, alu_op,
           instr_done, illegal, mem_err, state
  );

  modport slave (
    output run, op, func, mem_ready,
    input  pc_write, ir_write, mem_read, mem_write, reg_write,
           reg_dst, mem_to_reg, alu_src, sftmd, i_format,
           jr, jmp, jal, branch, nbranch, alu_op,
           instr_done, illegal, mem_err, state
  );
endinterface

// File: rtl/instr_class_decode.sv
// instr_class_decode: combinational op/func -> instruction class.
//   i_op, i_func : raw fields from the instruction register
//   o_class      : decoded class (CL_ILLEGAL when nothing matches)
//   o_shift      : R-format func is one of the shift operations
module instr_class_decode
  import ctrl_pkg::*;
#(
  parameter int OP_WIDTH   = 6,
  parameter int FUNC_WIDTH = 6
) (
  input  logic [OP_WIDTH-1:0]   i_op,
  input  logic [FUNC_WIDTH-1:0] i_func,
  output class_t                o_class,
  output logic                  o_shift
);
  logic [5:0] w_func6;
  assign w_func6 = 6'(i_func);
  assign o_shift = is_shift(w_func6);

  always_comb begin
    o_class = CL_ILLEGAL;
    if (i_op == OP_WIDTH'(OP_R_FORMAT))
      o_class = (w_func6 == FUNC_JR) ? CL_JR : CL_R;
    else if (i_op == OP_WIDTH'(OP_LW))      o_class = CL_LW;
    else if (i_op == OP_WIDTH'(OP_SW))      o_class = CL_SW;
    else if (i_op == OP_WIDTH'(OP_BRANCH))  o_class = CL_BEQ;
    else if (i_op == OP_WIDTH'(OP_NBRANCH)) o_class = CL_BNE;
    else if (i_op == OP_WIDTH'(OP_JMP))     o_class = CL_J;
    else if (i_op == OP_WIDTH'(OP_JAL))     o_class = CL_JAL;
    else if (i_op[5:3] == OP_I_FORMAT)      o_class = CL_I;
  end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing FETCH/DECODE/EXECUTE/MEM/WB/JUMP.
//   clk, rst_n : clock, async active-low reset
//   bus        : multicycle_controller_if.master (run/op/func/mem_ready in,
//                datapath strobes, selects, instr_done/illegal/mem_err/state out)
// Every FETCH/MEM wait is bounded by MEM_TIMEOUT; a timeout sets the sticky
// mem_err and parks the FSM in IDLE until reset.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int OP_WIDTH    = 6,
  parameter int FUNC_WIDTH  = 6,
  parameter int MEM_TIMEOUT = 16
) (
  input logic clk,
  input logic rst_n,
  multicycle_controller_if.master bus
);
  localparam int CW = $clog2(MEM_TIMEOUT);

  state_t    r_state, w_next;
  class_t    r_class, w_class;
  logic      r_shift, w_shift;
  logic [CW-1:0] r_cnt;
  logic      r_err;
  logic      w_wait, w_tmo;
  ctrl_out_t w_out;

  instr_class_decode #(.OP_WIDTH(OP_WIDTH), .FUNC_WIDTH(FUNC_WIDTH)) u_dec (
    .i_op    (bus.op),
    .i_func  (bus.func),
    .o_class (w_class),
    .o_shift (w_shift)
  );

  assign w_wait = (r_state == ST_FETCH) || (r_state == ST_MEM);
  // Ready on the last allowed cycle still wins over the timeout.
  assign w_tmo  = w_wait && !bus.mem_ready && (r_cnt == CW'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_class <= CL_ILLEGAL;
      r_shift <= 1'b0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DECODE) begin
        r_class <= w_class;
        r_shift <= w_shift;
      end
      // Any state change clears the counter, which covers MEM->FETCH for SW.
      if (r_state != w_next)                r_cnt <= '0;
      else if (w_wait && !bus.mem_ready)    r_cnt <= r_cnt + 1'b1;
      if (w_tmo) r_err <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    w_out  = '0;
    case (r_state)
      ST_IDLE: if (bus.run && !r_err) w_next = ST_FETCH;
      ST_FETCH: begin
        w_out.mem_read = 1'b1;
        if (bus.mem_ready) begin
          w_out.ir_write = 1'b1;
          w_out.pc_write = 1'b1;
          w_next         = ST_DECODE;
        end else if (w_tmo) begin
          w_next = ST_IDLE;
        end
      end
      ST_DECODE: w_next = (r_class_is_jump(w_class)) ? ST_JUMP : ST_EXECUTE;
      ST_EXECUTE: begin
        w_out.alu_op = {(r_class == CL_R) || (r_class == CL_I),
                        (r_class == CL_BEQ) || (r_class == CL_BNE)};
        case (r_class)
          CL_BEQ, CL_BNE: begin
            w_out.branch     = (r_class == CL_BEQ);
            w_out.nbranch    = (r_class == CL_BNE);
            w_out.pc_write   = 1'b1;
            w_out.instr_done = 1'b1;
            w_next           = ST_FETCH;
          end
          CL_JR: begin
            w_out.jr         = 1'b1;
            w_out.pc_write   = 1'b1;
            w_out.instr_done = 1'b1;
            w_next           = ST_FETCH;
          end
          CL_LW, CL_SW: begin
            w_out.alu_src = 1'b1;
            w_next        = ST_MEM;
          end
          CL_R, CL_I: w_next = ST_WB;
          default: begin
            w_out.illegal    = 1'b1;
            w_out.instr_done = 1'b1;
            w_next           = ST_FETCH;
          end
        endcase
      end
      ST_MEM: begin
        w_out.mem_read  = (r_class == CL_LW);
        w_out.mem_write = (r_class != CL_LW);
        if (bus.mem_ready) begin
          if (r_class == CL_LW) begin
            w_next = ST_WB;
          end else begin
            w_out.instr_done = 1'b1;
            w_next           = ST_FETCH;
          end
        end else if (w_tmo) begin
          w_next = ST_IDLE;
        end
      end
      ST_WB: begin
        w_out.reg_write  = 1'b1;
        w_out.instr_done = 1'b1;
        w_out.reg_dst    = (r_class == CL_R);
        w_out.sftmd      = (r_class == CL_R) && r_shift;
        w_out.mem_to_reg = (r_class == CL_LW);
        w_out.i_format   = (r_class == CL_I);
        w_next           = ST_FETCH;
      end
      ST_JUMP: begin
        w_out.jmp        = 1'b1;
        w_out.pc_write   = 1'b1;
        w_out.jal        = (r_class == CL_JAL);
        w_out.reg_write  = (r_class == CL_JAL);
        w_out.instr_done = 1'b1;
        w_next           = ST_FETCH;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  function automatic logic r_class_is_jump(input class_t c);
    return (c == CL_J) || (c == CL_JAL);
  endfunction

  assign bus.pc_write   = w_out.pc_write;
  assign bus.ir_write   = w_out.ir_write;
  assign bus.mem_read   = w_out.mem_read;
  assign bus.mem_write  = w_out.mem_write;
  assign bus.reg_write  = w_out.reg_write;
  assign bus.reg_dst    = w_out.reg_dst;
  assign bus.mem_to_reg = w_out.mem_to_reg;
  assign bus.alu_src    = w_out.alu_src;
  assign bus.sftmd      = w_out.sftmd;
  assign bus.i_format   = w_out.i_format;
  assign bus.jr         = w_out.jr;
  assign bus.jmp        = w_out.jmp;
  assign bus.jal        = w_out.jal;
  assign bus.branch     = w_out.branch;
  assign bus.nbranch    = w_out.nbranch;
  assign bus.alu_op     = w_out.alu_op;
  assign bus.instr_done = w_out.instr_done;
  assign bus.illegal    = w_out.illegal;
  assign bus.mem_err    = r_err;
  assign bus.state      = r_state;
endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: each issued instruction pushes its expected cycle count,
// fetch/mem read count, done-cycle outputs and OR of all outputs; a monitor
// pops and compares on every instr_done.
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_controller_if #(.OP_WIDTH(6), .FUNC_WIDTH(6)) bif ();
  multicycle_controller #(.OP_WIDTH(6), .FUNC_WIDTH(6), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif.master)
  );

  localparam logic [17:0] PCW = 18'd1 << 0,  IRW = 18'd1 << 1,  MRD = 18'd1 << 2;
  localparam logic [17:0] MWR = 18'd1 << 3,  RGW = 18'd1 << 4,  RDS = 18'd1 << 5;
  localparam logic [17:0] M2R = 18'd1 << 6,  ASR = 18'd1 << 7,  SFT = 18'd1 << 8;
  localparam logic [17:0] IFM = 18'd1 << 9,  JRB = 18'd1 << 10, JMP = 18'd1 << 11;
  localparam logic [17:0] JAL = 18'd1 << 12, BRN = 18'd1 << 13, NBR = 18'd1 << 14;
  localparam logic [17:0] ILL = 18'd1 << 15, AO0 = 18'd1 << 16, AO1 = 18'd1 << 17;
  localparam logic [17:0] ALL = 18'h3FFFF;
  localparam logic [17:0] NOA1 = ALL & ~AO1;
  localparam logic [17:0] FET = PCW | IRW | MRD;

  typedef struct {
    string       name;
    int          cyc;
    int          rd;
    logic [17:0] done_v;
    logic [17:0] seen_v;
    logic [17:0] mask;
  } exp_t;

  exp_t sbq[$];
  int n_vec = 0;
  int n_err = 0;
  int fetch_wait = 0;
  int mem_wait = 0;

  function automatic logic [17:0] outv();
    return {bif.alu_op[1], bif.alu_op[0], bif.illegal, bif.nbranch, bif.branch,
            bif.jal, bif.jmp, bif.jr, bif.i_format, bif.sftmd, bif.alu_src,
            bif.mem_to_reg, bif.reg_dst, bif.reg_write, bif.mem_write,
            bif.mem_read, bif.ir_write, bif.pc_write};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // Memory model: ready after fetch_wait / mem_wait idle cycles in the state.
  logic [2:0] prev_st = 3'd0;
  int wcnt = 0;
  always @(negedge clk) begin
    if (bif.state != prev_st) wcnt = 0;
    prev_st = bif.state;
    if (bif.state == 3'd1)      bif.mem_ready = (wcnt >= fetch_wait);
    else if (bif.state == 3'd4) bif.mem_ready = (wcnt >= mem_wait);
    else                        bif.mem_ready = 1'b0;
    wcnt++;
  end

  // Monitor
  int m_cyc = 0;
  int m_rd = 0;
  logic [17:0] m_seen = '0;
  logic [17:0] m_v;
  exp_t m_e;
  always @(negedge clk) begin
    #2;
    if (!rst_n || bif.state == 3'd0) begin
      m_cyc = 0; m_rd = 0; m_seen = '0;
    end else begin
      m_v = outv();
      m_cyc++;
      m_rd += int'(bif.mem_read);
      m_seen |= m_v;
      if (bif.instr_done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 32'(bif.instr_done), 32'd0);
        end else begin
          m_e = sbq.pop_front();
          chk({m_e.name, "_cycles"}, m_cyc, m_e.cyc);
          chk({m_e.name, "_reads"}, m_rd, m_e.rd);
          chk({m_e.name, "_done_outs"}, 32'(m_v & m_e.mask), 32'(m_e.done_v & m_e.mask));
          chk({m_e.name, "_all_outs"}, 32'(m_seen & m_e.mask), 32'(m_e.seen_v & m_e.mask));
        end
        m_cyc = 0; m_rd = 0; m_seen = '0;
      end
    end
  end

  task automatic wait_done(input string nm);
    logic ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #3;
      if (bif.instr_done) begin ok = 1'b1; break; end
    end
    chk({nm, "_done_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic issue(input string nm, input logic [5:0] o, input logic [5:0] f,
                       input int fw, input int mw, input int cyc, input int rd,
                       input logic [17:0] dv, input logic [17:0] sv, input logic [17:0] mk);
    exp_t e;
    bif.op = o; bif.func = f; fetch_wait = fw; mem_wait = mw;
    e.name = nm; e.cyc = cyc; e.rd = rd; e.done_v = dv; e.seen_v = sv; e.mask = mk;
    sbq.push_back(e);
    bif.run = 1'b1;
    wait_done(nm);
  endtask

  initial begin
    logic ok;
    int nw;
    bif.run = 1'b0; bif.op = '0; bif.func = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", 32'(bif.state), 32'd0);
    chk("rst_outputs", 32'(outv()), 32'd0);
    chk("rst_mem_err", 32'(bif.mem_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk); #3;
    chk("idle_no_run", 32'(bif.state), 32'd0);

    //     name     op     func  fw mw cyc rd done_v          seen_v                        mask
    issue("add",  6'h00, 6'h20, 0, 0, 4, 1, RGW|RDS,        FET|AO1|RGW|RDS,              ALL);
    issue("sll",  6'h00, 6'h00, 0, 0, 4, 1, RGW|RDS|SFT,    FET|AO1|RGW|RDS|SFT,          ALL);
    issue("addi", 6'h08, 6'h00, 0, 0, 4, 1, RGW|IFM,        FET|AO1|RGW|IFM,              ALL);
    issue("lw",   6'h23, 6'h00, 0, 2, 7, 4, RGW|M2R,        FET|ASR|RGW|M2R,              ALL);
    issue("sw",   6'h2B, 6'h00, 0, 0, 4, 1, MWR,            FET|ASR|MWR,                  ALL);
    issue("beq",  6'h04, 6'h00, 0, 0, 3, 1, PCW|BRN|AO0,    FET|BRN|AO0,                  ALL);
    issue("bne",  6'h05, 6'h00, 0, 0, 3, 1, PCW|NBR|AO0,    FET|NBR|AO0,                  NOA1);
    issue("jr",   6'h00, 6'h08, 0, 0, 3, 1, PCW|JRB,        FET|JRB,                      NOA1);
    issue("j",    6'h02, 6'h00, 0, 0, 3, 1, PCW|JMP,        FET|JMP,                      ALL);
    issue("jal",  6'h03, 6'h00, 0, 0, 3, 1, PCW|JMP|JAL|RGW, FET|JMP|JAL|RGW,             ALL);
    issue("ill",  6'h3F, 6'h00, 0, 0, 3, 1, ILL,            FET|ILL,                      ALL);
    // ready arrives on the last allowed fetch cycle: still a success
    issue("add_fw3", 6'h00, 6'h20, 3, 0, 7, 4, RGW|RDS,     FET|AO1|RGW|RDS,              ALL);
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    // SW whose memory never answers: 4 MEM cycles then IDLE with mem_err.
    bif.op = 6'h2B; bif.func = '0; fetch_wait = 0; mem_wait = 99;
    ok = 1'b0; nw = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #3;
      if (bif.mem_write) nw++;
      if (bif.state == 3'd0) begin ok = 1'b1; break; end
    end
    chk("tmo_reached_idle", 32'(ok), 32'd1);
    chk("tmo_mem_write_cycles", nw, 32'd4);
    chk("tmo_mem_err", 32'(bif.mem_err), 32'd1);
    repeat (5) @(negedge clk);
    #3;
    chk("err_blocks_run_state", 32'(bif.state), 32'd0);
    chk("err_blocks_outputs", 32'(outv()), 32'd0);
    chk("err_sticky", 32'(bif.mem_err), 32'd1);

    @(negedge clk); rst_n = 1'b0;
    #1 chk("rst_clears_err", 32'(bif.mem_err), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Reset landing mid-MEM of a SW.
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #3;
      if (bif.state == 3'd4) begin ok = 1'b1; break; end
    end
    chk("mid_mem_reached", 32'(ok), 32'd1);
    @(negedge clk); #3;
    chk("mid_mem_write", 32'(bif.mem_write), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_outputs", 32'(outv()), 32'd0);
    chk("mid_rst_done", 32'(bif.instr_done), 32'd0);
    chk("mid_rst_state", 32'(bif.state), 32'd0);
    bif.run = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    chk("post_rst_state", 32'(bif.state), 32'd0);
    chk("sb_empty_end", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
